// File: rtl/instr_pack.sv
// Shared opcode, register-index and load-FSM types for reg_file_param.
// Also holds the parameter defaults used by reg_file_param and reg_incdec.
// Type definitions only; no logic, no latency, no flow control.
package instr_pack;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 16;
    localparam int PC_W_DEF     = 10;
    localparam int REG_IDX_W    = $clog2(NUM_REGS_DEF);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        LIT_LO = 4'd1,
        LIT_HI = 4'd2,
        MOV    = 4'd3,
        LOAD   = 4'd4,
        STORE  = 4'd5,
        INCR   = 4'd6,
        DECR   = 4'd7,
        BIZ    = 4'd8,
        BNZ    = 4'd9,
        JMP    = 4'd10
    } reg_OP;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_WAIT = 1'b1
    } ld_state_e;

endpackage

// File: rtl/reg_incdec.sv
// Increment, decrement and half-word literal merge for one register value.
// Purely combinational, zero latency.
// No flow control; results are consumed by the register file on its write cycle.
module reg_incdec
    import instr_pack::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   val,
    input  logic [DATA_W/2-1:0] imm,
    output logic [DATA_W-1:0]   inc_val,
    output logic [DATA_W-1:0]   dec_val,
    output logic [DATA_W-1:0]   lo_val,
    output logic [DATA_W-1:0]   hi_val
);

    localparam int HALF = DATA_W / 2;

    // Wrap-around is the natural behaviour of the fixed-width add/subtract.
    assign inc_val = val + DATA_W'(1);
    assign dec_val = val - DATA_W'(1);
    assign lo_val  = {val[DATA_W-1:HALF], imm};
    assign hi_val  = {imm, val[HALF-1:0]};

endmodule

// File: rtl/reg_file_param.sv
// Register file with literal/move/inc/dec/store ops, branching PC and a single outstanding load.
// State updates on the falling edge of clk; define REG_FILE_BYPASS_EN to forward ld_data onto rd_a/rd_b.
// op_ready is low while a load is outstanding; ops presented then are ignored and pc holds.
module reg_file_param
    import instr_pack::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int PC_W     = PC_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  reg_OP                       reg_op,
    input  logic [$clog2(NUM_REGS)-1:0] reg_src,
    input  logic [$clog2(NUM_REGS)-1:0] reg_dst,
    input  logic [DATA_W/2-1:0]         imm,
    input  logic [DATA_W-1:0]           ext_r,
    input  logic [DATA_W-1:0]           ext_s,
    output logic                        op_ready,
    output logic                        ld_req,
    input  logic [DATA_W-1:0]           ld_data,
    input  logic                        ld_valid,
    output logic                        st_valid,
    output logic [DATA_W-1:0]           st_data,
    output logic [DATA_W-1:0]           rd_a,
    output logic [DATA_W-1:0]           rd_b,
    output logic [PC_W-1:0]             pc
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int LINK  = NUM_REGS - 2;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [PC_W-1:0]   pc_q, pc_d;
    ld_state_e         state_q, state_d;
    logic [IDX_W-1:0]  ld_dst_q, ld_dst_d;
    logic              ld_req_q, ld_req_d;
    logic              st_valid_q, st_valid_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic              op_ready_q, op_ready_d;

    logic [DATA_W-1:0] src_val, dst_val;
    logic [DATA_W-1:0] inc_val, dec_val, lo_val, hi_val;
    logic [PC_W-1:0]   link_pc;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_val;

    assign src_val = regs_q[reg_src];
    assign dst_val = regs_q[reg_dst];
    assign link_pc = PC_W'(regs_q[LINK]);

    reg_incdec #(.DATA_W(DATA_W)) u_incdec (
        .val     (dst_val),
        .imm     (imm),
        .inc_val (inc_val),
        .dec_val (dec_val),
        .lo_val  (lo_val),
        .hi_val  (hi_val)
    );

    always_comb begin
        regs_d     = regs_q;
        pc_d       = pc_q;
        state_d    = state_q;
        ld_dst_d   = ld_dst_q;
        ld_req_d   = 1'b0;
        st_valid_d = 1'b0;
        st_data_d  = st_data_q;
        wr_en      = 1'b0;
        wr_idx     = reg_dst;
        wr_val     = '0;

        case (state_q)
            LD_IDLE: begin
                pc_d = pc_q + PC_W'(1);
                case (reg_op)
                    LIT_LO: begin wr_en = 1'b1; wr_val = lo_val;  end
                    LIT_HI: begin wr_en = 1'b1; wr_val = hi_val;  end
                    INCR:   begin wr_en = 1'b1; wr_val = inc_val; end
                    DECR:   begin wr_en = 1'b1; wr_val = dec_val; end
                    MOV: begin
                        wr_en  = 1'b1;
                        wr_val = (reg_src == reg_dst) ? '0 : src_val;
                    end
                    STORE: begin
                        st_valid_d = 1'b1;
                        st_data_d  = src_val;
                    end
                    LOAD: begin
                        ld_req_d = 1'b1;
                        ld_dst_d = reg_dst;
                        state_d  = LD_WAIT;
                    end
                    BIZ: if (src_val == '0) pc_d = link_pc;
                    BNZ: if (src_val != '0) pc_d = link_pc;
                    JMP: pc_d = link_pc;
                    default: ;
                endcase
            end
            LD_WAIT: begin
                if (ld_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = ld_dst_q;
                    wr_val  = ld_data;
                    state_d = LD_IDLE;
                end
            end
        endcase

        // Regs 0 and 1 are pure mirrors of ext_r/ext_s, so any write to them is dropped.
        if (wr_en && (wr_idx[IDX_W-1:1] != '0)) regs_d[wr_idx] = wr_val;
        regs_d[0] = ext_r;
        regs_d[1] = ext_s;

        op_ready_d = (state_d == LD_IDLE);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            pc_q       <= '0;
            state_q    <= LD_IDLE;
            ld_dst_q   <= '0;
            ld_req_q   <= 1'b0;
            st_valid_q <= 1'b0;
            st_data_q  <= '0;
            op_ready_q <= 1'b1;
        end else begin
            regs_q     <= regs_d;
            pc_q       <= pc_d;
            state_q    <= state_d;
            ld_dst_q   <= ld_dst_d;
            ld_req_q   <= ld_req_d;
            st_valid_q <= st_valid_d;
            st_data_q  <= st_data_d;
            op_ready_q <= op_ready_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic ld_wr;
    assign ld_wr = (state_q == LD_WAIT) && ld_valid && (ld_dst_q[IDX_W-1:1] != '0);
    assign rd_a  = (ld_wr && (ld_dst_q == reg_src)) ? ld_data : src_val;
    assign rd_b  = (ld_wr && (ld_dst_q == reg_dst)) ? ld_data : dst_val;
`else
    assign rd_a = src_val;
    assign rd_b = dst_val;
`endif

    assign op_ready = op_ready_q;
    assign ld_req   = ld_req_q;
    assign st_valid = st_valid_q;
    assign st_data  = st_data_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed vector table, load/reset sequences and random ops vs a reference model.
module tb_reg_file_param;
    import instr_pack::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    reg_OP      reg_op = NOP;
    logic [3:0] reg_src = '0, reg_dst = '0, imm = '0;
    logic [7:0] ext_r = '0, ext_s = '0, ld_data = '0;
    logic       ld_valid = 1'b0;
    logic       op_ready, ld_req, st_valid;
    logic [7:0] st_data, rd_a, rd_b;
    logic [9:0] pc;

    reg_file_param #(.DATA_W(8), .NUM_REGS(16), .PC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .reg_op(reg_op), .reg_src(reg_src), .reg_dst(reg_dst),
        .imm(imm), .ext_r(ext_r), .ext_s(ext_s), .op_ready(op_ready), .ld_req(ld_req),
        .ld_data(ld_data), .ld_valid(ld_valid), .st_valid(st_valid), .st_data(st_data),
        .rd_a(rd_a), .rd_b(rd_b), .pc(pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: architectural state only.
    logic [7:0] m_regs [16];
    logic [9:0] m_pc;
    logic       m_wait;
    logic [3:0] m_dst;
    logic       m_st_v, m_ld_req;
    logic [7:0] m_st_data;

    typedef struct {
        logic [3:0] op;
        logic [3:0] src;
        logic [3:0] dst;
        logic [3:0] imm;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [9:0] epc;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_regs    = '{default: 8'h00};
        m_pc      = '0;
        m_wait    = 1'b0;
        m_dst     = '0;
        m_st_v    = 1'b0;
        m_ld_req  = 1'b0;
        m_st_data = '0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [3:0] src, input logic [3:0] dst,
                              input logic [3:0] iv, input logic [7:0] er, input logic [7:0] es,
                              input logic [7:0] ldd, input logic ldv);
        logic       wr;
        logic [3:0] widx;
        logic [7:0] wval;
        logic [9:0] nxt;
        wr = 1'b0; widx = dst; wval = '0;
        m_st_v = 1'b0; m_ld_req = 1'b0;
        if (!m_wait) begin
            nxt = m_pc + 10'd1;
            case (op)
                LIT_LO: begin wr = 1'b1; wval = (m_regs[dst] & 8'hF0) | {4'h0, iv}; end
                LIT_HI: begin wr = 1'b1; wval = (m_regs[dst] & 8'h0F) | {iv, 4'h0}; end
                MOV:    begin wr = 1'b1; wval = (src == dst) ? 8'h00 : m_regs[src]; end
                INCR:   begin wr = 1'b1; wval = m_regs[dst] + 8'd1; end
                DECR:   begin wr = 1'b1; wval = m_regs[dst] + 8'd255; end
                LOAD:   begin m_wait = 1'b1; m_dst = dst; m_ld_req = 1'b1; end
                STORE:  begin m_st_v = 1'b1; m_st_data = m_regs[src]; end
                BIZ:    if (m_regs[src] == 8'd0) nxt = {2'b00, m_regs[14]};
                BNZ:    if (m_regs[src] != 8'd0) nxt = {2'b00, m_regs[14]};
                JMP:    nxt = {2'b00, m_regs[14]};
                default: ;
            endcase
            m_pc = nxt;
        end else if (ldv) begin
            wr = 1'b1; widx = m_dst; wval = ldd; m_wait = 1'b0;
        end
        if (wr && widx > 4'd1) m_regs[widx] = wval;
        m_regs[0] = er;
        m_regs[1] = es;
    endtask

    // Drive one op, let the falling edge commit it, then compare everything against the model.
    task automatic apply(input logic [3:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic [3:0] iv, input logic [7:0] er, input logic [7:0] es,
                         input logic [7:0] ldd, input logic ldv);
        reg_op = reg_OP'(op); reg_src = src; reg_dst = dst; imm = iv;
        ext_r = er; ext_s = es; ld_data = ldd; ld_valid = ldv;
        model_step(op, src, dst, iv, er, es, ldd, ldv);
        @(negedge clk);
        #1;
        ld_valid = 1'b0;
        #1;
        chk("pc", int'(pc), int'(m_pc));
        chk("op_ready", int'(op_ready), int'(!m_wait));
        chk("ld_req", int'(ld_req), int'(m_ld_req));
        chk("st_valid", int'(st_valid), int'(m_st_v));
        chk("st_data", int'(st_data), int'(m_st_data));
        chk("rd_a", int'(rd_a), int'(m_regs[src]));
        chk("rd_b", int'(rd_b), int'(m_regs[dst]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_low;
        int n_req;
        logic [9:0] pc_at_load;

        tbl[0]  = '{LIT_LO, 4'd8,  4'd8,  4'h5, 8'h05, 8'h05, 10'h001};
        tbl[1]  = '{LIT_HI, 4'd8,  4'd8,  4'hA, 8'hA5, 8'hA5, 10'h002};
        tbl[2]  = '{LIT_LO, 4'd6,  4'd6,  4'hF, 8'h0F, 8'h0F, 10'h003};
        tbl[3]  = '{LIT_HI, 4'd6,  4'd6,  4'hF, 8'hFF, 8'hFF, 10'h004};
        tbl[4]  = '{INCR,   4'd6,  4'd6,  4'h0, 8'h00, 8'h00, 10'h005};
        tbl[5]  = '{DECR,   4'd6,  4'd6,  4'h0, 8'hFF, 8'hFF, 10'h006};
        tbl[6]  = '{LIT_LO, 4'd4,  4'd4,  4'hC, 8'h0C, 8'h0C, 10'h007};
        tbl[7]  = '{LIT_HI, 4'd4,  4'd4,  4'h3, 8'h3C, 8'h3C, 10'h008};
        tbl[8]  = '{MOV,    4'd4,  4'd4,  4'h0, 8'h00, 8'h00, 10'h009};
        tbl[9]  = '{MOV,    4'd8,  4'd5,  4'h0, 8'hA5, 8'hA5, 10'h00A};
        tbl[10] = '{LIT_LO, 4'd14, 4'd14, 4'h0, 8'h00, 8'h00, 10'h00B};
        tbl[11] = '{LIT_HI, 4'd14, 4'd14, 4'h4, 8'h40, 8'h40, 10'h00C};
        tbl[12] = '{BIZ,    4'd7,  4'd14, 4'h0, 8'h00, 8'h40, 10'h040};
        tbl[13] = '{BNZ,    4'd7,  4'd14, 4'h0, 8'h00, 8'h40, 10'h041};
        tbl[14] = '{JMP,    4'd5,  4'd14, 4'h0, 8'hA5, 8'h40, 10'h040};
        tbl[15] = '{MOV,    4'd5,  4'd0,  4'h0, 8'hA5, 8'h11, 10'h041};
        tbl[16] = '{INCR,   4'd1,  4'd1,  4'h0, 8'h22, 8'h22, 10'h042};
        tbl[17] = '{STORE,  4'd8,  4'd3,  4'h0, 8'hA5, 8'h00, 10'h043};
        tbl[18] = '{4'hF,   4'd8,  4'd8,  4'h0, 8'hA5, 8'hA5, 10'h044};
        tbl[19] = '{BNZ,    4'd8,  4'd2,  4'h0, 8'hA5, 8'h00, 10'h040};

        // Reset state, with ext inputs already non-zero.
        ext_r = 8'h11; ext_s = 8'h22; reg_src = 4'd0; reg_dst = 4'd14;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", int'(pc), 0);
        chk("rst_op_ready", int'(op_ready), 1);
        chk("rst_ld_req", int'(ld_req), 0);
        chk("rst_st_valid", int'(st_valid), 0);
        chk("rst_st_data", int'(st_data), 0);
        chk("rst_rd_a_r0", int'(rd_a), 0);
        chk("rst_rd_b_r14", int'(rd_b), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].imm, 8'h11, 8'h22, 8'h00, 1'b0);
            chk($sformatf("vec%0d_rd_a", i), int'(rd_a), int'(tbl[i].ea));
            chk($sformatf("vec%0d_rd_b", i), int'(rd_b), int'(tbl[i].eb));
            chk($sformatf("vec%0d_pc", i), int'(pc), int'(tbl[i].epc));
            if (i == 17) begin
                chk("store_st_valid", int'(st_valid), 1);
                chk("store_st_data", int'(st_data), 8'hA5);
            end
            if (i == 18) chk("store_pulse_end", int'(st_valid), 0);
        end

        // LOAD r9: ld_valid low on the LOAD cycle and two wait cycles, then high with 0x77.
        n_low = 0; n_req = 0;
        apply(LOAD, 4'd9, 4'd9, 4'h0, 8'h11, 8'h22, 8'h00, 1'b0);
        pc_at_load = pc;
        if (!op_ready) n_low++;
        if (ld_req) n_req++;
        for (int w = 0; w < 2; w++) begin
            apply(INCR, 4'd9, 4'd9, 4'h0, 8'h11, 8'h22, 8'h00, 1'b0);
            chk("load_wait_pc_hold", int'(pc), int'(pc_at_load));
            if (!op_ready) n_low++;
            if (ld_req) n_req++;
        end
        reg_op = NOP; reg_src = 4'd9; reg_dst = 4'd9; ld_data = 8'h77; ld_valid = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_rd_a", int'(rd_a), 8'h77);
`else
        chk("no_bypass_rd_a", int'(rd_a), int'(m_regs[9]));
`endif
        apply(NOP, 4'd9, 4'd9, 4'h0, 8'h11, 8'h22, 8'h77, 1'b1);
        if (!op_ready) n_low++;
        if (ld_req) n_req++;
        chk("load_ready_low_cycles", n_low, 3);
        chk("load_req_pulses", n_req, 1);
        chk("load_r9", int'(rd_a), 8'h77);
        chk("load_done_pc", int'(pc), int'(pc_at_load));

        // ld_valid in IDLE is ignored.
        apply(NOP, 4'd9, 4'd9, 4'h0, 8'h11, 8'h22, 8'h99, 1'b1);
        chk("idle_ldv_ignored", int'(rd_b), 8'h77);

        // Load to reg 0 completes the handshake but keeps the mirror.
        apply(LOAD, 4'd0, 4'd0, 4'h0, 8'h11, 8'h22, 8'h00, 1'b0);
        apply(NOP, 4'd0, 4'd0, 4'h0, 8'h11, 8'h22, 8'h55, 1'b1);
        chk("load_r0_ready", int'(op_ready), 1);
        chk("load_r0_discard", int'(rd_a), 8'h11);

        // Reset during WAIT, then a late ld_valid.
        apply(LOAD, 4'd8, 4'd10, 4'h0, 8'h11, 8'h22, 8'h00, 1'b0);
        apply(NOP, 4'd8, 4'd10, 4'h0, 8'h11, 8'h22, 8'h00, 1'b0);
        chk("wait_before_reset", int'(op_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_op_ready", int'(op_ready), 1);
        chk("rst_wait_pc", int'(pc), 0);
        chk("rst_wait_r8", int'(rd_a), 0);
        chk("rst_wait_st_data", int'(st_data), 0);
        #1 rst_n = 1'b1;
        model_reset();
        apply(NOP, 4'd8, 4'd10, 4'h0, 8'h11, 8'h22, 8'hEE, 1'b1);
        chk("late_ldv_r10", int'(rd_b), 0);
        chk("late_ldv_ready", int'(op_ready), 1);

        // Random ops against the model.
        for (int r = 0; r < 400; r++) begin
            apply(4'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()),
                  8'($urandom()), 8'($urandom()), 8'($urandom()),
                  ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
